// File: rtl/ibuffer_pkg.sv
// Types shared by the instruction buffer: one queued fetch record.
`include "defines.sv"

package ibuffer_pkg;

    // One fetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [`PC_RANGE]    pc;
        logic [`INSTR_RANGE] instr;
    } ibuf_entry_t;

endpackage

// File: rtl/defines.sv
// Shared core-wide defines: PC/instruction field ranges and structure sizes.
`ifndef DEFINES_SV
`define DEFINES_SV

`define PC_RANGE    31:0
`define INSTR_RANGE 31:0
`define IBUF_DEPTH  8

`endif

// File: rtl/ibuffer.sv
// Instruction buffer: circular FIFO of {pc, instr} between fetch and decode.
// Head is read combinationally from storage (no fall-through), pops are held
// off by mem_stall, and redirect_valid empties the buffer in one cycle.
`include "defines.sv"

module ibuffer
    import ibuffer_pkg::*;
#(
    parameter int DEPTH = `IBUF_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 fetch_valid,
    output logic                 fetch_ready,
    input  logic [`PC_RANGE]     fetch_pc,
    input  logic [`INSTR_RANGE]  fetch_instr,
    output logic                 ibuf_valid,
    input  logic                 ibuf_ready,
    output logic [`PC_RANGE]     ibuf_pc,
    output logic [`INSTR_RANGE]  ibuf_instr,
    input  logic                 mem_stall,
    input  logic                 redirect_valid,
    output logic [CNT_W-1:0]     ibuf_count
);

    localparam int IDX_W = $clog2(DEPTH);

    ibuf_entry_t      entry [DEPTH];
    ibuf_entry_t      head;
    logic [CNT_W-1:0] wptr;
    logic [CNT_W-1:0] rptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    // Wrap bit (MSB) distinguishes full from empty when the index bits match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]) &&
                   (wptr[CNT_W-1] != rptr[CNT_W-1]);

    // fetch_ready looks only at fullness so it never depends on a same-cycle pop.
    assign fetch_ready = ~full;
    assign ibuf_valid  = ~empty;
    assign push        = fetch_valid & fetch_ready & ~redirect_valid;
    assign pop         = ibuf_valid & ibuf_ready & ~mem_stall;
    assign ibuf_count  = wptr - rptr;

    assign head       = entry[rptr[IDX_W-1:0]];
    assign ibuf_pc    = head.pc;
    assign ibuf_instr = head.instr;

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clock) begin
        if (push) begin
            entry[wptr[IDX_W-1:0]] <= '{pc: fetch_pc, instr: fetch_instr};
        end
    end

    // Pointer update; a redirect collapses rptr onto wptr, overriding any pop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (redirect_valid) begin
                rptr <= wptr;
            end else if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ibuffer.sv
// Bench for ibuffer: table of per-cycle vectors with expected occupancy, a
// scoreboard queue of accepted fetches checked against every pop, and
// hand-written streaming and asynchronous-reset sequences.
module tb_ibuffer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             fetch_valid;
    logic             fetch_ready;
    logic [31:0]      fetch_pc;
    logic [31:0]      fetch_instr;
    logic             ibuf_valid;
    logic             ibuf_ready;
    logic [31:0]      ibuf_pc;
    logic [31:0]      ibuf_instr;
    logic             mem_stall;
    logic             redirect_valid;
    logic [CNT_W-1:0] ibuf_count;

    ibuffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_pc       (fetch_pc),
        .fetch_instr    (fetch_instr),
        .ibuf_valid     (ibuf_valid),
        .ibuf_ready     (ibuf_ready),
        .ibuf_pc        (ibuf_pc),
        .ibuf_instr     (ibuf_instr),
        .mem_stall      (mem_stall),
        .redirect_valid (redirect_valid),
        .ibuf_count     (ibuf_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_item_t;

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic        rdy;
        logic        stall;
        logic        redir;
        int          exp_count;
        logic        exp_valid;
        logic        exp_ready;
    } vec_t;

    sb_item_t sb[$];
    vec_t     vecs[$];
    int       total = 0;
    int       bad   = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic fv, input logic [31:0] pc, input logic rdy,
                       input logic st, input logic rd, input int ec,
                       input logic ev, input logic er);
        vec_t v;
        v.fv = fv; v.pc = pc; v.rdy = rdy; v.stall = st; v.redir = rd;
        v.exp_count = ec; v.exp_valid = ev; v.exp_ready = er;
        vecs.push_back(v);
    endtask

    // One clock cycle: drive, sample at negedge, check, advance the model.
    task automatic cycle(input logic fv, input logic [31:0] pc, input logic rdy,
                         input logic st, input logic rd, input bit use_exp,
                         input int ec, input logic ev, input logic er);
        logic     m_pop;
        logic     m_push;
        sb_item_t it;
        fetch_valid    = fv;
        fetch_pc       = pc;
        fetch_instr    = instr_of(pc);
        ibuf_ready     = rdy;
        mem_stall      = st;
        redirect_valid = rd;
        @(negedge clock);
        chk("count_model", 64'(ibuf_count), 64'(sb.size()));
        chk("valid_model", 64'(ibuf_valid), 64'(sb.size() != 0));
        chk("ready_model", 64'(fetch_ready), 64'(sb.size() < DEPTH));
        if (use_exp) begin
            chk("count_vec", 64'(ibuf_count), 64'(ec));
            chk("valid_vec", 64'(ibuf_valid), 64'(ev));
            chk("ready_vec", 64'(fetch_ready), 64'(er));
        end
        m_pop  = (sb.size() != 0) && rdy && !st;
        m_push = fv && (sb.size() < DEPTH) && !rd;
        if (m_pop) begin
            it = sb.pop_front();
            chk("head_pc", 64'(ibuf_pc), 64'(it.pc));
            chk("head_instr", 64'(ibuf_instr), 64'(it.instr));
        end
        if (rd) sb.delete();
        else if (m_push) begin
            it.pc = pc; it.instr = instr_of(pc);
            sb.push_back(it);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] base;
        reset_n = 1'b0; fetch_valid = 1'b0; fetch_pc = '0; fetch_instr = '0;
        ibuf_ready = 1'b0; mem_stall = 1'b0; redirect_valid = 1'b0;

        // Fill: 9 offers with decode not ready; the 9th is refused.
        base = 32'h8000_0000;
        for (int i = 0; i < 9; i++)
            add(1, base + 32'(4*i), 0, 0, 0, i, i != 0, i < 8);
        add(0, 0, 0, 0, 0, 8, 1, 0);
        // Drain in order.
        for (int i = 0; i < 8; i++) add(0, 0, 1, 0, 0, 8 - i, 1, i != 0);
        add(0, 0, 0, 0, 0, 0, 0, 1);
        // Stall with three entries.
        for (int i = 0; i < 3; i++) add(1, 32'h8000_0100 + 32'(4*i), 0, 0, 0, i, i != 0, 1);
        for (int i = 0; i < 4; i++) add(0, 0, 1, 1, 0, 3, 1, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 0, 3 - i, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1);
        // Redirect with five entries and a same-cycle fetch.
        for (int i = 0; i < 5; i++) add(1, 32'h8000_0200 + 32'(4*i), 0, 0, 0, i, i != 0, 1);
        add(1, 32'h8000_0900, 0, 0, 1, 5, 1, 1);
        add(1, 32'h8000_1000, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 1, 1);
        add(0, 0, 1, 0, 0, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1);
        // Redirect with stall, then redirect with a completing pop.
        add(1, 32'h8000_0300, 0, 0, 0, 0, 0, 1);
        add(1, 32'h8000_0304, 0, 0, 0, 1, 1, 1);
        add(0, 0, 1, 1, 1, 2, 1, 1);
        add(1, 32'h8000_0400, 0, 0, 0, 0, 0, 1);
        add(1, 32'h8000_0404, 0, 0, 0, 1, 1, 1);
        add(0, 0, 1, 0, 1, 2, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1);

        // Reset state.
        #12;
        chk("rst_valid", 64'(ibuf_valid), 64'd0);
        chk("rst_ready", 64'(fetch_ready), 64'd1);
        chk("rst_count", 64'(ibuf_count), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        foreach (vecs[i])
            cycle(vecs[i].fv, vecs[i].pc, vecs[i].rdy, vecs[i].stall, vecs[i].redir,
                  1'b1, vecs[i].exp_count, vecs[i].exp_valid, vecs[i].exp_ready);

        // Streaming across the pointer wrap: occupancy settles at one.
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 32'h8000_2000 + 32'(4*i), 1'b1, 1'b0, 1'b0,
                  1'b1, (i == 0) ? 0 : 1, i != 0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1);

        // Asynchronous reset with four entries held.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'h8000_3000 + 32'(4*i), 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        fetch_valid = 1'b0;
        #1;
        chk("pre_arst_count", 64'(ibuf_count), 64'd4);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 64'(ibuf_valid), 64'd0);
        chk("arst_count", 64'(ibuf_count), 64'd0);
        chk("arst_ready", 64'(fetch_ready), 64'd1);
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        idle();
        cycle(1'b1, 32'h8000_4000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
